// File: rtl/alu_issue_ctrl.sv
// Issue controller for the ALU: owns a small register file and runs each
// instruction through IDLE -> ISSUE -> CAPTURE. Optional debug read port: DBG_READ_EN.
module alu_issue_ctrl #(
    parameter int N    = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_dst,
    input  logic [AW-1:0] in_src_a,
    input  logic [AW-1:0] in_src_b,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [N-1:0]  ld_data,
    output logic          alu_enable,
    output logic [2:0]    alu_mode,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    input  logic [N-1:0]  alu_out,
    input  logic          alu_flag_zero,
    input  logic          alu_flag_carry,
    output logic          flag_zero,
    output logic          flag_carry,
`ifdef DBG_READ_EN
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data,
`endif
    output logic          done
);

    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    rf [NREG];
    logic [2:0]      op_q;
    logic [AW-1:0]   dst_q;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr) < 32'(NREG);
    endfunction

    function automatic logic [N-1:0] rd(input logic [AW-1:0] addr);
        return in_range(addr) ? rf[addr] : '0;
    endfunction

    assign in_ready = (state == IDLE);

`ifdef DBG_READ_EN
    always_comb begin
        dbg_data = rd(dbg_addr);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            dst_q      <= '0;
            alu_enable <= 1'b0;
            alu_mode   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            done       <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            done <= 1'b0;
            // Direct load comes first so a same-register writeback below overrides it.
            if (ld_en && in_range(ld_addr)) rf[ld_addr] <= ld_data;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        dst_q      <= in_dst;
                        alu_mode   <= in_op;
                        alu_a      <= rd(in_src_a);
                        alu_b      <= rd(in_src_b);
                        alu_enable <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_enable <= 1'b0;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    if (op_q != OP_CMP && in_range(dst_q)) rf[dst_q] <= alu_out;
                    flag_zero  <= alu_flag_zero;
                    flag_carry <= alu_flag_carry;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a small ALU model answers issued ops,
// a negedge monitor checks each ALU issue and each done pulse against queued expectations.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [1:0] in_dst = '0, in_src_a = '0, in_src_b = '0;
    logic       ld_en = 1'b0;
    logic [1:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       alu_enable;
    logic [2:0] alu_mode;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_out = '0;
    logic       alu_flag_zero = 1'b0, alu_flag_carry = 1'b0;
    logic       flag_zero, flag_carry, done;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct packed { logic [2:0] mode; logic [7:0] a; logic [7:0] b; } issue_t;
    typedef struct packed { logic z; logic c; } done_t;
    issue_t exp_issue[$];
    done_t  exp_done[$];

    alu_issue_ctrl #(.N(8), .NREG(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_flag_zero(alu_flag_zero), .alu_flag_carry(alu_flag_carry),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .done(done)
    );

    always #5 clk = ~clk;

    // ALU model: samples on the edge where alu_enable is high, result stable for capture.
    always @(posedge clk) begin
        logic [8:0] s;
        if (alu_enable) begin
            case (alu_mode)
                3'b111: begin
                    s = {1'b0, alu_a} - {1'b0, alu_b};
                    alu_out        <= s[7:0];
                    alu_flag_zero  <= (s[7:0] == 8'h00);
                    alu_flag_carry <= (alu_a < alu_b);
                end
                default: begin
                    s = {1'b0, alu_a} + {1'b0, alu_b};
                    alu_out        <= s[7:0];
                    alu_flag_zero  <= (s[7:0] == 8'h00);
                    alu_flag_carry <= s[8];
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compares every ALU issue and every done pulse against the scoreboard.
    logic prev_en = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        issue_t ei;
        done_t  ed;
        if (rst_n) begin
            if (alu_enable) begin
                check("alu_enable_single_cycle", {31'd0, prev_en}, 32'd0);
                if (exp_issue.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
                else begin
                    ei = exp_issue.pop_front();
                    check("issue_mode", {29'd0, alu_mode}, {29'd0, ei.mode});
                    check("issue_a", {24'd0, alu_a}, {24'd0, ei.a});
                    check("issue_b", {24'd0, alu_b}, {24'd0, ei.b});
                end
            end
            if (done) begin
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (exp_done.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    ed = exp_done.pop_front();
                    check("flag_zero", {31'd0, flag_zero}, {31'd0, ed.z});
                    check("flag_carry", {31'd0, flag_carry}, {31'd0, ed.c});
                end
            end
        end
        prev_en   = alu_enable;
        prev_done = done;
    end

    // All tasks start and end at 1 time unit after a posedge.
    task automatic ld(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [7:0] ea, input logic [7:0] eb,
                         input logic ez, input logic ec, input logic push_done);
        bit ok = 1'b0;
        exp_issue.push_back('{mode: op, a: ea, b: eb});
        if (push_done) exp_done.push_back('{z: ez, c: ec});
        in_valid = 1'b1; in_op = op; in_dst = dst; in_src_a = sa; in_src_b = sb;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
    endtask

    // Non-destructive register read: CMP r,r issues reg value on both operands.
    task automatic peek(input logic [1:0] r, input logic [7:0] v);
        issue(3'b111, r, r, r, v, v, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        int acc[2];
        int n, lows;
        bit rdy;

        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_enable", {31'd0, alu_enable}, 32'd0);
        check("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
        check("rst_done_flags", {29'd0, done, flag_zero, flag_carry}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // 1: basic ADD
        ld(2'd0, 8'h05); ld(2'd1, 8'h03);
        issue(3'b000, 2'd2, 2'd0, 2'd1, 8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
        peek(2'd2, 8'h08);

        // 2: ADD overflow sets Z and C
        ld(2'd0, 8'hFF); ld(2'd1, 8'h01);
        issue(3'b000, 2'd3, 2'd0, 2'd1, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b1);
        peek(2'd3, 8'h00);

        // 3: CMP does not write back
        ld(2'd0, 8'h07);
        issue(3'b111, 2'd0, 2'd0, 2'd0, 8'h07, 8'h07, 1'b1, 1'b0, 1'b1);
        peek(2'd0, 8'h07);

        // 4: in_valid held across two ops; second reads first's result
        exp_issue.push_back('{mode: 3'b000, a: 8'h01, b: 8'h07});
        exp_done.push_back('{z: 1'b0, c: 1'b0});
        exp_issue.push_back('{mode: 3'b000, a: 8'h08, b: 8'h07});
        exp_done.push_back('{z: 1'b0, c: 1'b0});
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; in_op = 3'b000; in_dst = 2'd1; in_src_a = 2'd1; in_src_b = 2'd0;
        n = 0; lows = 0;
        for (int c = 0; c < 12 && n < 2; c++) begin
            rdy = in_ready;
            if (!rdy && n == 1) lows++;
            @(posedge clk); #1;
            if (rdy) begin acc[n] = c; n++; end
        end
        in_valid = 1'b0;
        check("b2b_accepts", n, 2);
        check("b2b_spacing", acc[1] - acc[0], 3);
        check("b2b_ready_low", lows, 2);
        peek(2'd1, 8'h0F);

        // 5a: load in CAPTURE to the writeback target loses to writeback
        issue(3'b000, 2'd2, 2'd0, 2'd1, 8'h07, 8'h0F, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        ld(2'd2, 8'hAA);
        peek(2'd2, 8'h16);

        // 5b: load to a source during ISSUE does not affect the in-flight op
        issue(3'b000, 2'd3, 2'd1, 2'd0, 8'h0F, 8'h07, 1'b0, 1'b0, 1'b1);
        ld(2'd1, 8'h50);
        peek(2'd1, 8'h50);
        peek(2'd3, 8'h16);

        // 6: reset during ISSUE drops the op
        ld(2'd0, 8'h11);
        issue(3'b000, 2'd2, 2'd0, 2'd0, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_enable", {31'd0, alu_enable}, 32'd0);
        check("async_rst_ab", {16'd0, alu_a, alu_b}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        peek(2'd0, 8'h00);
        peek(2'd2, 8'h00);

        repeat (6) @(posedge clk);
        #1;
        check("issue_queue_drained", exp_issue.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
